// File: rtl/max_pool_2x2_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | max_pool_2x2_stream_if                                                   |
// | Valid/ready stream bundle for the 2x2 max-pool stage (pixel in,          |
// | pooled result out).                                                      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface max_pool_2x2_stream_if #(
  parameter int DATA_W = 18
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  // Pooling stage side: consumes pixels, produces pooled results.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  // Surrounding pipeline side: supplies pixels, absorbs results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/max_pool_2x2_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | max_pool_2x2_stream                                                      |
// | Streaming 2x2 / stride-2 signed max-pool over a raster-order frame.      |
// | Even rows leave horizontal-pair maxima in a half-width line buffer;      |
// | odd rows combine them with their own pair maxima to emit one result.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module max_pool_2x2_stream #(
  parameter int In_d_W = 18,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  wire logic               clk,
  input  wire logic               clr_n,
  input  wire logic               frame_rst,
  max_pool_2x2_stream_if.slave    bus
);

  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int IDX_W    = (IMG_W / 2 > 1) ? $clog2(IMG_W / 2) : 1;
  localparam int LB_DEPTH = 1 << IDX_W;

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [In_d_W-1:0] h_max;
  logic signed [In_d_W-1:0] pool_data;
  logic                     pool_valid;
  logic                     pool_last;
  logic signed [In_d_W-1:0] lbuf [LB_DEPTH];

  logic                     in_ready;
  logic                     accept;
  logic                     advance;
  logic                     col_last;
  logic                     row_last;
  logic [IDX_W-1:0]         lb_idx;
  logic signed [In_d_W-1:0] in_px;
  logic signed [In_d_W-1:0] h_pair;
  logic signed [In_d_W-1:0] lb_rd;
  logic signed [In_d_W-1:0] v_max;
  logic                     lb_wr;
  logic                     pool_load;

  // Input may enter whenever the output register is empty or draining.
  assign in_ready  = ~pool_valid | bus.out_ready;
  assign accept    = bus.in_valid & in_ready;
  // A restart discards whatever beat happens to be offered that cycle.
  assign advance   = accept & ~frame_rst;

  assign col_last  = (col == COL_W'(IMG_W - 1));
  assign row_last  = (row == ROW_W'(IMG_H - 1));
  assign lb_idx    = IDX_W'(col >> 1);
  assign in_px     = bus.in_data;

  // Signed comparisons: both operands are declared signed.
  assign h_pair    = (in_px > h_max) ? in_px : h_max;
  assign lb_rd     = lbuf[lb_idx];
  assign v_max     = (lb_rd > h_pair) ? lb_rd : h_pair;

  assign lb_wr     = advance & col[0] & ~row[0];
  assign pool_load = advance & col[0] & row[0];

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = pool_valid;
  assign bus.out_data  = pool_data;
  assign bus.out_last  = pool_last;

  // Raster position counters, advanced once per accepted pixel.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      col <= '0;
      row <= '0;
    end else if (frame_rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Left pixel of each horizontal pair is held until its right partner arrives.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      h_max <= '0;
    end else if (advance && !col[0]) begin
      h_max <= in_px;
    end
  end

  // Even-row pair maxima wait here until the odd row below reads them back.
  always_ff @(posedge clk) begin
    if (lb_wr) begin
      lbuf[lb_idx] <= h_pair;
    end
  end

  // Output register: a new result wins over draining; otherwise hold until taken.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pool_valid <= 1'b0;
      pool_data  <= '0;
      pool_last  <= 1'b0;
    end else if (frame_rst) begin
      pool_valid <= 1'b0;
      pool_last  <= 1'b0;
    end else if (pool_load) begin
      pool_valid <= 1'b1;
      pool_data  <= v_max;
      pool_last  <= row_last & col_last;
    end else if (bus.out_ready) begin
      pool_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_2x2_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_max_pool_2x2_stream                                                   |
// | Scoreboard bench for the 2x2 max-pool stage on a 4x4 frame.              |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_max_pool_2x2_stream;

  localparam int DW = 18;
  localparam int IW = 4;
  localparam int IH = 4;

  logic clk;
  logic clr_n;
  logic frame_rst;

  int total;
  int bad;
  int n_out;
  int n_last;
  bit rand_ready;

  logic [DW:0]           exp_q [$];
  int                    m_col;
  int                    m_row;
  logic signed [DW-1:0]  pix [IH][IW];

  max_pool_2x2_stream_if #(.DATA_W(DW)) bus ();

  max_pool_2x2_stream #(
    .In_d_W (DW),
    .IMG_W  (IW),
    .IMG_H  (IH)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .frame_rst (frame_rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Reference model: records the frame and pushes a window result at each bottom-right pixel.
  task automatic model_accept(input logic signed [DW-1:0] d);
    logic signed [DW-1:0] mx;
    logic                 lst;
    pix[m_row][m_col] = d;
    if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
      mx  = smax(smax(pix[m_row-1][m_col-1], pix[m_row-1][m_col]),
                 smax(pix[m_row][m_col-1], d));
      lst = (m_row == IH - 1) && (m_col == IW - 1);
      exp_q.push_back({lst, mx});
    end
    m_col++;
    if (m_col == IW) begin
      m_col = 0;
      m_row++;
      if (m_row == IH) m_row = 0;
    end
  endtask

  task automatic model_clear();
    m_col = 0;
    m_row = 0;
  endtask

  // Offer one pixel (after optional idle cycles) and wait until it is taken.
  task automatic drive_beat(input logic signed [DW-1:0] d, input int idle);
    int guard;
    guard = 0;
    bus.in_valid = 1'b0;
    repeat (idle) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL in_stall: in_ready=%0b after %0d cycles, required 1", bus.in_ready, guard);
    end else begin
      model_accept(d);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been observed.
  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_%s: pending=%0d, required 0", tag, exp_q.size());
    end
  endtask

  // Compares every completed output handshake against the scoreboard.
  task automatic monitor();
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (clr_n && bus.out_valid && bus.out_ready) begin
        n_out++;
        if (bus.out_last) n_last++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected: got data=%0d last=%0b, required no output",
                   bus.out_data, bus.out_last);
        end else begin
          e = exp_q.pop_front();
          if ({bus.out_last, bus.out_data} !== e) begin
            bad++;
            $display("FAIL out_stream: got data=%0d last=%0b, required data=%0d last=%0b",
                     bus.out_data, bus.out_last, $signed(e[DW-1:0]), e[DW]);
          end
        end
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic test_reset();
    clr_n         = 1'b0;
    frame_rst     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 18'sd123;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid);
    end
    total++;
    if (bus.out_data !== '0) begin
      bad++; $display("FAIL reset_out_data: got %0d, required 0", bus.out_data);
    end
    total++;
    if (bus.out_last !== 1'b0) begin
      bad++; $display("FAIL reset_out_last: got %0b, required 0", bus.out_last);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
    end
    bus.in_valid = 1'b0;
    clr_n        = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame_seq();
    logic                 ev;
    logic signed [DW-1:0] ed;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      drive_beat(DW'(k), 0);
      ev = (k == 6) || (k == 8) || (k == 14) || (k == 16);
      total++;
      if (bus.out_valid !== ev) begin
        bad++;
        $display("FAIL seq_latency_px%0d: out_valid=%0b, required %0b", k, bus.out_valid, ev);
      end
      if (ev) begin
        ed = DW'(k);
        total++;
        if (bus.out_data !== ed || bus.out_last !== (k == 16)) begin
          bad++;
          $display("FAIL seq_value_px%0d: data=%0d last=%0b, required data=%0d last=%0b",
                   k, bus.out_data, bus.out_last, ed, (k == 16));
        end
      end
    end
    drain("seq");
  endtask

  task automatic test_negatives();
    logic signed [DW-1:0] ed;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_beat((i == 5) ? -18'sd2 : -18'sd5, 0);
      if (i == 5) begin
        ed = -18'sd2;
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== ed) begin
          bad++;
          $display("FAIL neg_first: valid=%0b data=%0d, required valid=1 data=%0d",
                   bus.out_valid, bus.out_data, ed);
        end
      end
    end
    drain("neg");
  endtask

  task automatic test_backpressure();
    logic signed [DW-1:0] ed;
    ed = 18'sd6;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) drive_beat(DW'(k), 0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 18'sd7;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_valid: got %0b, required 1", bus.out_valid);
      end
      total++;
      if (bus.out_data !== ed) begin
        bad++; $display("FAIL bp_hold: got %0d, required %0d", bus.out_data, ed);
      end
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_in_ready: got %0b, required 0", bus.in_ready);
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 7; k <= 16; k++) drive_beat(DW'(k), 0);
    drain("bp");
  endtask

  task automatic test_back_to_back();
    int out0;
    int last0;
    int v;
    out0  = n_out;
    last0 = n_last;
    rand_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 16; p++) begin
        v = int'($urandom_range(0, 2000)) - 1000;
        drive_beat(DW'(v), int'($urandom_range(0, 2)));
      end
    end
    drain("b2b");
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    total++;
    if (n_out - out0 != 12) begin
      bad++; $display("FAIL b2b_count: got %0d, required 12", n_out - out0);
    end
    total++;
    if (n_last - last0 != 3) begin
      bad++; $display("FAIL b2b_last: got %0d, required 3", n_last - last0);
    end
  endtask

  task automatic test_frame_rst();
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) drive_beat(DW'(k), 0);
    frame_rst    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 18'sd99;
    @(posedge clk);
    #1;
    frame_rst    = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL frst_clear: out_valid=%0b, required 0", bus.out_valid);
    end
    for (int k = 1; k <= 16; k++) drive_beat(DW'(k), 0);
    drain("frst");
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) drive_beat(DW'(k) + 18'sd40, 0);
    #2;
    clr_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      bad++;
      $display("FAIL async_reset: valid=%0b data=%0d, required valid=0 data=0",
               bus.out_valid, bus.out_data);
    end
    exp_q.delete();
    model_clear();
    @(negedge clk);
    clr_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) drive_beat(DW'(k), 0);
    drain("arst");
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    n_out      = 0;
    n_last     = 0;
    rand_ready = 1'b0;
    m_col      = 0;
    m_row      = 0;
    fork
      monitor();
      ready_driver();
    join_none
    test_reset();
    test_frame_seq();
    test_negatives();
    test_backpressure();
    test_back_to_back();
    test_frame_rst();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
